// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the four-requester round-robin arbiter.
//   NREQ         : number of requesters (4)
//   IDW          : width of an encoded requester index (2)
//   arb_state_t  : arbiter FSM states (IDLE = nobody holds, BUSY = one holder)
//   onehot_to_id : encodes a one-hot requester vector to its binary index
// ---------------------------------------------------------------------------
package arb_pkg;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Encodes a one-hot vector; an all-zero input encodes to index 0.
    function automatic logic [IDW-1:0] onehot_to_id(input logic [NREQ-1:0] oh);
        logic [IDW-1:0] id;
        id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                id = IDW'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches req (after masking) in the
// order ptr, ptr+1, ptr+2, ptr+3 (mod 4) and reports the first hit.
// Ports:
//   req     in  4 : raw request vector
//   ptr     in  2 : index checked first
//   mask    in  4 : 1 = requester may be picked (used to exclude the holder)
//   found   out 1 : some masked request exists
//   pick_id out 2 : index of the chosen requester (0 when nothing found)
// ---------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic [NREQ-1:0] mask,
    output logic            found,
    output logic [IDW-1:0]  pick_id
);

    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] pick_oh;
    logic [IDW-1:0]  idx;

    assign cand = req & mask;

    // Walk the rotated search order; the 2-bit index add wraps naturally
    // so the search rolls over from i3 back to i0.
    always_comb begin
        found   = 1'b0;
        pick_oh = '0;
        idx     = ptr;
        for (int off = 0; off < NREQ; off++) begin
            idx = ptr + IDW'(off);
            if (!found && cand[idx]) begin
                found        = 1'b1;
                pick_oh[idx] = 1'b1;
            end
        end
    end

    assign pick_id = onehot_to_id(pick_oh);

endmodule

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4
// Four-requester round-robin arbiter with hold-time preemption. A granted
// requester keeps the resource until it drops req; if others are waiting it
// is preempted after HOLD_MAX cycles of grant.
// Parameters:
//   HOLD_MAX : max grant cycles under contention (2..255)
//   CW       : hold counter width, 2**CW > HOLD_MAX
// Ports:
//   clk       in  1 : clock, rising edge
//   rst_n     in  1 : asynchronous active-low reset
//   req       in  4 : level request per requester
//   gnt       out 4 : registered one-hot grant (0 when idle)
//   gnt_id    out 2 : registered index of holder; holds value when idle
//   gnt_valid out 1 : registered, high while a grant is active
//   preempt   out 1 : one-cycle pulse when the grant moved due to timeout
// ---------------------------------------------------------------------------
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CW       = 8
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_valid,
    output logic            preempt
);

    arb_state_t      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_d;
    logic [IDW-1:0]  gnt_id_d;
    logic            gnt_valid_d;
    logic            preempt_d;

    logic            holder_req;
    logic            others_req;
    logic            at_limit;
    logic [IDW-1:0]  next_ptr;
    logic [IDW-1:0]  pick_ptr;
    logic [NREQ-1:0] pick_mask;
    logic            found;
    logic [IDW-1:0]  pick_id;

    // In BUSY, gnt is the holder's one-hot vector. Every move out of BUSY
    // re-searches from holder+1 with the holder excluded, so the single
    // picker is steered that way whenever a holder exists.
    assign holder_req = |(req & gnt);
    assign others_req = |(req & ~gnt);
    assign at_limit   = (cnt_q == CW'(HOLD_MAX - 1));
    assign next_ptr   = gnt_id + IDW'(1);
    assign pick_ptr   = (state_q == BUSY) ? next_ptr : ptr_q;
    assign pick_mask  = (state_q == BUSY) ? ~gnt : {NREQ{1'b1}};

    rr_pick u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .mask    (pick_mask),
        .found   (found),
        .pick_id (pick_id)
    );

    // Next-state logic: release is checked before timeout so a holder that
    // lets go at its limit never produces a preempt pulse.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt;
        gnt_id_d    = gnt_id;
        gnt_valid_d = gnt_valid;
        preempt_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = BUSY;
                    gnt_d       = NREQ'(1) << pick_id;
                    gnt_id_d    = pick_id;
                    gnt_valid_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                end
            end
            BUSY: begin
                if (!holder_req) begin
                    ptr_d = next_ptr;
                    if (found) begin
                        gnt_d    = NREQ'(1) << pick_id;
                        gnt_id_d = pick_id;
                        cnt_d    = '0;
                    end else begin
                        state_d     = IDLE;
                        gnt_d       = '0;
                        gnt_valid_d = 1'b0;
                    end
                end else if (others_req && at_limit) begin
                    ptr_d     = next_ptr;
                    gnt_d     = NREQ'(1) << pick_id;
                    gnt_id_d  = pick_id;
                    cnt_d     = '0;
                    preempt_d = 1'b1;
                end else if (!others_req) begin
                    cnt_d = at_limit ? cnt_q : cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears the grant without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt       <= gnt_d;
            gnt_id    <= gnt_id_d;
            gnt_valid <= gnt_valid_d;
            preempt   <= preempt_d;
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter4
// Self-checking bench for rr_arbiter4 (HOLD_MAX = 8). Directed scenarios
// check fixed expectations; a random phase compares against a reference
// model that tracks holder, pointer and cycles-held as plain integers.
// ---------------------------------------------------------------------------
module tb_rr_arbiter4;

    localparam int HOLD_MAX = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    int n_checks;
    int n_errors;

    // Reference model state: holder (-1 = none), search start, cycles the
    // holder has owned the grant, last granted index, preempt expectation.
    int   m_holder;
    int   m_ptr;
    int   m_held;
    int   m_last;
    logic m_pre;

    rr_arbiter4 #(.HOLD_MAX(HOLD_MAX), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First requesting index at or after start, wrapping mod 4.
    function automatic int first_from(input int start, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_gnt();
        return (m_holder >= 0) ? 4'(1 << m_holder) : 4'b0000;
    endfunction

    task automatic model_reset();
        m_holder = -1;
        m_ptr    = 0;
        m_held   = 0;
        m_last   = 0;
        m_pre    = 1'b0;
    endtask

    // One rising edge of arbitration rules applied to request vector r.
    task automatic model_edge(input logic [3:0] r);
        logic [3:0] rest;
        m_pre = 1'b0;
        if (m_holder < 0) begin
            m_holder = first_from(m_ptr, r);
            m_held   = 1;
        end else if (!r[m_holder]) begin
            m_ptr    = (m_holder + 1) % 4;
            m_holder = first_from(m_ptr, r);
            m_held   = 1;
        end else begin
            rest = r;
            rest[m_holder] = 1'b0;
            if (rest != 4'b0000 && m_held >= HOLD_MAX) begin
                m_ptr    = (m_holder + 1) % 4;
                m_holder = first_from(m_ptr, rest);
                m_held   = 1;
                m_pre    = 1'b1;
            end else if (m_held < HOLD_MAX) begin
                m_held++;
            end
        end
        if (m_holder >= 0) m_last = m_holder;
    endtask

    // Drive req, take one rising edge, advance the model, settle at negedge.
    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset values visible while reset is held.
    task automatic test_reset();
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (gnt !== 4'b0000 || gnt_id !== 2'd0 || gnt_valid !== 1'b0 || preempt !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_values: got gnt=%b id=%0d v=%b p=%b want 0000/0/0/0",
                     gnt, gnt_id, gnt_valid, preempt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single requester grant then release.
    task automatic test_single();
        do_reset();
        step(4'b0001);
        n_checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_valid !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL single_grant: got gnt=%b id=%0d v=%b want 0001/0/1", gnt, gnt_id, gnt_valid);
        end
        step(4'b0000);
        n_checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin
            n_errors++;
            $display("[TB] FAIL single_release: got gnt=%b id=%0d v=%b want 0000/0/0", gnt, gnt_id, gnt_valid);
        end
    endtask

    // All four request; each holder keeps 2 cycles then drops its bit.
    task automatic test_back_to_back();
        logic [3:0] r;
        do_reset();
        r = 4'b1111;
        step(r);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 2; c++) begin
                n_checks++;
                if (gnt !== 4'(1 << k) || gnt_id !== 2'(k) || gnt_valid !== 1'b1 || preempt !== 1'b0) begin
                    n_errors++;
                    $display("[TB] FAIL rr_sequence k=%0d c=%0d: got gnt=%b id=%0d v=%b p=%b want gnt=%b id=%0d v=1 p=0",
                             k, c, gnt, gnt_id, gnt_valid, preempt, 4'(1 << k), k);
                end
                if (c == 1) r[k] = 1'b0;
                step(r);
            end
        end
        n_checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd3) begin
            n_errors++;
            $display("[TB] FAIL rr_sequence_end: got gnt=%b id=%0d v=%b want 0000/3/0", gnt, gnt_id, gnt_valid);
        end
    endtask

    // Pointer sits at 2 while i2 holds; release must skip i1.
    task automatic test_ptr_order();
        logic [3:0] others [2];
        logic [3:0] want   [2];
        others[0] = 4'b0011; want[0] = 4'b0001;
        others[1] = 4'b1011; want[1] = 4'b1000;
        for (int v = 0; v < 2; v++) begin
            do_reset();
            step(4'b0010);
            step(4'b0000);
            step(4'b0100);
            step(4'b0100 | others[v]);
            n_checks++;
            if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
                n_errors++;
                $display("[TB] FAIL ptr_hold v=%0d: got gnt=%b id=%0d want 0100/2", v, gnt, gnt_id);
            end
            step(others[v]);
            n_checks++;
            if (gnt !== want[v] || gnt_id !== onehot_id(want[v]) || gnt_valid !== 1'b1 || preempt !== 1'b0) begin
                n_errors++;
                $display("[TB] FAIL ptr_handover v=%0d: got gnt=%b id=%0d v=%b p=%b want %b",
                         v, gnt, gnt_id, gnt_valid, preempt, want[v]);
            end
        end
    endtask

    function automatic logic [1:0] onehot_id(input logic [3:0] oh);
        return oh[3] ? 2'd3 : oh[2] ? 2'd2 : oh[1] ? 2'd1 : 2'd0;
    endfunction

    // i1 holds while i3 waits: exactly HOLD_MAX cycles, then preempt to i3.
    task automatic test_timeout();
        int cycles;
        do_reset();
        step(4'b1010);
        cycles = 0;
        while (gnt === 4'b0010 && cycles < 20) begin
            cycles++;
            step(4'b1010);
        end
        n_checks++;
        if (cycles != HOLD_MAX) begin
            n_errors++;
            $display("[TB] FAIL timeout_len: got %0d cycles want %0d", cycles, HOLD_MAX);
        end
        n_checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3 || preempt !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL timeout_move: got gnt=%b id=%0d p=%b want 1000/3/1", gnt, gnt_id, preempt);
        end
        step(4'b1000);
        n_checks++;
        if (gnt !== 4'b1000 || preempt !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL timeout_pulse: got gnt=%b p=%b want 1000/0", gnt, preempt);
        end
    endtask

    // Lone holder is never preempted; a newcomer after saturation wins at once.
    task automatic test_alone();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step(4'b0010);
            n_checks++;
            if (gnt !== 4'b0010 || preempt !== 1'b0) begin
                n_errors++;
                $display("[TB] FAIL alone_hold c=%0d: got gnt=%b p=%b want 0010/0", c, gnt, preempt);
            end
        end
        step(4'b0011);
        n_checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || preempt !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL alone_preempt: got gnt=%b id=%0d p=%b want 0001/0/1", gnt, gnt_id, preempt);
        end
    endtask

    // Reset between edges drops the grant immediately.
    task automatic test_async_reset();
        do_reset();
        step(4'b0100);
        step(4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 4'b0000 || gnt_id !== 2'd0 || gnt_valid !== 1'b0 || preempt !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL async_reset: got gnt=%b id=%0d v=%b p=%b want 0000/0/0/0",
                     gnt, gnt_id, gnt_valid, preempt);
        end
        model_reset();
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0000);
        step(4'b0100);
        n_checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_valid !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL post_reset_grant: got gnt=%b id=%0d v=%b want 0100/2/1", gnt, gnt_id, gnt_valid);
        end
    endtask

    // Random requests that flip rarely, so long holds and timeouts occur.
    task automatic test_random();
        logic [3:0] r;
        do_reset();
        r = 4'b0000;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
            end
            step(r);
            n_checks++;
            if (gnt !== m_gnt() || gnt_id !== 2'(m_last) || gnt_valid !== (m_holder >= 0) || preempt !== m_pre) begin
                n_errors++;
                $display("[TB] FAIL random c=%0d req=%b: got gnt=%b id=%0d v=%b p=%b want gnt=%b id=%0d v=%b p=%b",
                         c, r, gnt, gnt_id, gnt_valid, preempt, m_gnt(), m_last, (m_holder >= 0), m_pre);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        req      = 4'b0000;
        rst_n    = 1'b1;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_ptr_order();
        test_timeout();
        test_alone();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares one downstream resource, such as a 4-to-2 encoded select bus, between requesters i0..i3. It registers a one-hot grant plus its 2-bit encoded index. A granted requester holds the resource until it drops its request. A hold-time limit preempts long holders when others are waiting. The block sits between the requesters and the resource mux, which is selected directly by `gnt_id`.

## Interface
Parameters:
- `HOLD_MAX`, default 8: maximum cycles a holder keeps the grant while other requests are pending. Legal range is 2..255.
- `CW`, default 8: width of the hold counter. Must satisfy 2^CW > HOLD_MAX.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `req`  in  4  — request per requester; bit k belongs to ik. Level-sensitive; held high for the whole use of the resource.
- `gnt`  out  4  — registered one-hot grant. All zero when no grant is active.
- `gnt_id`  out  2  — registered binary index of the granted requester. Holds its last value when `gnt_valid`=0.
- `gnt_valid`  out  1  — registered; high while any grant is active.
- `preempt`  out  1  — one-cycle registered pulse, issued in the cycle the grant moves because of a timeout.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: one holder owns `gnt`.
- Priority pointer `ptr` (2 bits): the requester checked first. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- IDLE, `req`≠0: grant the first requesting index in search order and go to BUSY. Clear the hold counter.
- IDLE, `req`=0: stay in IDLE. Outputs are unchanged except `gnt`=0 and `gnt_valid`=0.
- BUSY, holder's `req` bit low (release):
  - Set `ptr` to holder+1.
  - If any other `req` bit is high, grant the next requester in the new search order in the same edge. This is a zero-gap handover; stay in BUSY and clear the counter.
  - Otherwise go to IDLE.
- BUSY, holder still requesting, counter = HOLD_MAX−1, and another `req` bit high (timeout):
  - Set `ptr` to holder+1.
  - Grant the next requester in search order and clear the counter.
  - Pulse `preempt` for one cycle.
- BUSY, holder still requesting, no other request: keep the grant. The counter saturates at HOLD_MAX−1 and the holder is never preempted while alone.
- BUSY otherwise: the counter increments by 1.
- Release and timeout in the same cycle: release wins and `preempt` stays 0.
- When multiple requests rise in the same cycle, the pick is decided by `ptr` only.
- A requester never sees `gnt` for a `req` bit that was low at the granting edge.
- The grant is never zero-length. Once a requester is granted, it keeps the grant for at least one cycle.

## Timing
- Reset values: `gnt`=4'b0000, `gnt_id`=2'b00, `gnt_valid`=0, `preempt`=0, `ptr`=0, counter=0, state IDLE.
- Reset is asynchronous. Asserting `rst_n` mid-grant drops `gnt` immediately, without waiting for a clock edge.
- Grant latency: `req` sampled high at edge N gives `gnt`/`gnt_id`/`gnt_valid` valid after edge N, i.e. in cycle N+1.
- Release latency: holder `req` sampled low at edge N gives `gnt` bit low after edge N. The next grant, if any, is valid in that same cycle.
- Maximum hold with contention: HOLD_MAX cycles of `gnt` high, then the grant moves.
- `gnt`, `gnt_id` and `gnt_valid` always change on the same edge. `gnt` and `gnt_id` are always consistent.

## Structure
- Package `arb_pkg`:
  - `NREQ`=4 and `IDW`=2.
  - State enum `arb_state_t` with values IDLE and BUSY.
  - Function `onehot_to_id` (4→2 encode).
- Sub-module `rr_pick`: purely combinational.
  - Inputs: `req[3:0]`, `ptr[1:0]`, and a 4-bit mask that excludes the current holder.
  - Outputs: `found` and `pick_id[1:0]`.
  - It is instantiated once. The FSM, pointer, counter and output registers live in `rr_arbiter4`.

## Test plan
- Reset, then `req`=4'b0001 → one cycle later `gnt`=0001, `gnt_id`=0, `gnt_valid`=1. Drop req → `gnt`=0000, `gnt_valid`=0 the next cycle.
- From reset, `req`=4'b1111 and each holder drops its bit after 2 cycles of grant → the grant sequence is i0, i1, i2, i3 with zero-gap handovers and `preempt` never set.
- With `ptr`=2, hold i2 and raise `req`=4'b0011 → after i2 releases, the grant goes to i3 if requesting, else i0, never i1 first. Check with `req`=4'b0111, which must give i0 after i2.
- Timeout with HOLD_MAX=8: i1 holds continuously while i3 requests → `gnt`=0010 for exactly 8 cycles, then `gnt`=1000, `gnt_id`=3 with `preempt`=1 for one cycle.
- i1 holds alone for 20 cycles → no preemption and the counter saturates. Raise i0 at cycle 20 → the grant moves to i0 on the next edge with `preempt`=1.
- Deassert `rst_n` between clock edges while i2 holds → outputs go to their reset values immediately. After release, `req`=4'b0100 is granted i2 one cycle later.
